// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer in front of the SPRAM-based RAM block.
// One request in flight at a time; illegal requests are answered with an error and never reach the RAM.
module ram_arbiter #(
    parameter int          ARB_MODE = 0,
    parameter logic [31:0] MAX_ADDR = 32'd32767
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid0,
    output logic        reqReady0,
    input  logic [31:0] reqAddr0,
    input  logic [31:0] reqWData0,
    input  logic        reqWrite0,
    input  logic [3:0]  reqMask0,
    output logic        respValid0,
    output logic [31:0] respData0,
    output logic        respErr0,
    input  logic        reqValid1,
    output logic        reqReady1,
    input  logic [31:0] reqAddr1,
    input  logic [31:0] reqWData1,
    input  logic        reqWrite1,
    input  logic [3:0]  reqMask1,
    output logic        respValid1,
    output logic [31:0] respData1,
    output logic        respErr1,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic [3:0]  byteMask,
    input  logic [31:0] memReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [3:0]  mask_q, mask_d;
    logic        err_q, err_d;

    logic        grant_en;
    logic        gnt0;
    logic        gnt1;
    logic        legal_read;

    // Only byte, half-word and word writes exist in the RAM; reads ignore the mask.
    function automatic logic req_err(input logic [31:0] addr, input logic write, input logic [3:0] mask);
        logic mask_bad;
        case (mask)
            4'b0001, 4'b0011, 4'b1111: mask_bad = 1'b0;
            default:                   mask_bad = 1'b1;
        endcase
        return (addr > MAX_ADDR) | (write & mask_bad);
    endfunction

    // Grant decision: only while no access is on the RAM pins, never while reset is held.
    always_comb begin
        grant_en = ~reset & ((state_q == IDLE) | (state_q == RESP));
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (grant_en) begin
            if (ARB_MODE == 1) begin
                if (reqValid0) begin
                    gnt0 = 1'b1;
                end else if (reqValid1) begin
                    gnt1 = 1'b1;
                end
            end else begin
                if (reqValid0 && reqValid1) begin
                    gnt0 = last_grant_q;
                    gnt1 = ~last_grant_q;
                end else if (reqValid0) begin
                    gnt0 = 1'b1;
                end else if (reqValid1) begin
                    gnt1 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            mask_q       <= 4'b1111;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        mask_d       = mask_q;
        err_d        = err_q;

        case (state_q)
            IDLE:    state_d = (gnt0 | gnt1) ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = (gnt0 | gnt1) ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase

        if (gnt0) begin
            last_grant_d = 1'b0;
            owner_d      = 1'b0;
            addr_d       = reqAddr0;
            wdata_d      = reqWData0;
            write_d      = reqWrite0;
            mask_d       = reqMask0;
            err_d        = req_err(reqAddr0, reqWrite0, reqMask0);
        end else if (gnt1) begin
            last_grant_d = 1'b1;
            owner_d      = 1'b1;
            addr_d       = reqAddr1;
            wdata_d      = reqWData1;
            write_d      = reqWrite1;
            mask_d       = reqMask1;
            err_d        = req_err(reqAddr1, reqWrite1, reqMask1);
        end
    end

    // RAM pins come straight from the latched request; a rejected request still reads harmlessly.
    always_comb begin
        reqReady0    = gnt0;
        reqReady1    = gnt1;
        memAddress   = addr_q;
        memWriteData = wdata_q;
        byteMask     = mask_q;
        memWrite     = (state_q == ACCESS) & write_q & ~err_q;
        legal_read   = ~write_q & ~err_q;
        respValid0   = (state_q == RESP) & ~owner_q;
        respValid1   = (state_q == RESP) & owner_q;
        respErr0     = respValid0 & err_q;
        respErr1     = respValid1 & err_q;
        respData0    = (respValid0 & legal_read) ? memReadData : 32'h0;
        respData1    = (respValid1 & legal_read) ? memReadData : 32'h0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each backed by its own behavioural SPRAM with one-cycle read latency.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;
    logic        w0 = 1'b0, w1 = 1'b0;
    logic [3:0]  m0 = 4'b1111, m1 = 4'b1111;

    logic        rdy0_a, rdy1_a, rv0_a, rv1_a, re0_a, re1_a, mw_a;
    logic [31:0] rd0_a, rd1_a, maddr_a, mwd_a, mrd_a;
    logic [3:0]  bm_a;
    logic        rdy0_b, rdy1_b, rv0_b, rv1_b, re0_b, re1_b, mw_b;
    logic [31:0] rd0_b, rd1_b, maddr_b, mwd_b, mrd_b;
    logic [3:0]  bm_b;

    logic [31:0] mem_a [0:32767];
    logic [31:0] mem_b [0:32767];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ARB_MODE(0), .MAX_ADDR(32'd32767)) dut_rr (
        .clk(clk), .reset(reset),
        .reqValid0(v0), .reqReady0(rdy0_a), .reqAddr0(a0), .reqWData0(d0), .reqWrite0(w0), .reqMask0(m0),
        .respValid0(rv0_a), .respData0(rd0_a), .respErr0(re0_a),
        .reqValid1(v1), .reqReady1(rdy1_a), .reqAddr1(a1), .reqWData1(d1), .reqWrite1(w1), .reqMask1(m1),
        .respValid1(rv1_a), .respData1(rd1_a), .respErr1(re1_a),
        .memAddress(maddr_a), .memWriteData(mwd_a), .memWrite(mw_a), .byteMask(bm_a), .memReadData(mrd_a)
    );

    ram_arbiter #(.ARB_MODE(1), .MAX_ADDR(32'd32767)) dut_fp (
        .clk(clk), .reset(reset),
        .reqValid0(v0), .reqReady0(rdy0_b), .reqAddr0(a0), .reqWData0(d0), .reqWrite0(w0), .reqMask0(m0),
        .respValid0(rv0_b), .respData0(rd0_b), .respErr0(re0_b),
        .reqValid1(v1), .reqReady1(rdy1_b), .reqAddr1(a1), .reqWData1(d1), .reqWrite1(w1), .reqMask1(m1),
        .respValid1(rv1_b), .respData1(rd1_b), .respErr1(re1_b),
        .memAddress(maddr_b), .memWriteData(mwd_b), .memWrite(mw_b), .byteMask(bm_b), .memReadData(mrd_b)
    );

    // Behavioural SPRAM: byte-masked write, registered read.
    always @(posedge clk) begin
        if (maddr_a < 32'd32768) begin
            if (mw_a) begin
                for (int b = 0; b < 4; b++)
                    if (bm_a[b]) mem_a[maddr_a[14:0]][8*b +: 8] <= mwd_a[8*b +: 8];
            end
            mrd_a <= mem_a[maddr_a[14:0]];
        end else begin
            mrd_a <= 32'h0BAD_0BAD;
        end
    end

    always @(posedge clk) begin
        if (maddr_b < 32'd32768) begin
            if (mw_b) begin
                for (int b = 0; b < 4; b++)
                    if (bm_b[b]) mem_b[maddr_b[14:0]][8*b +: 8] <= mwd_b[8*b +: 8];
            end
            mrd_b <= mem_b[maddr_b[14:0]];
        end else begin
            mrd_b <= 32'h0BAD_0BAD;
        end
    end

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        v0 = 1'b0;
        v1 = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // One complete transaction on the round-robin instance, starting from IDLE.
    task automatic do_txn(input vec_t v, input int idx);
        int   waited;
        logic rdy, rv, re, rv_other;
        logic [31:0] rd;
        waited = 0;
        if (v.port == 0) begin
            v0 = 1'b1; a0 = v.addr; d0 = v.wdata; w0 = v.wr; m0 = v.mask;
        end else begin
            v1 = 1'b1; a1 = v.addr; d1 = v.wdata; w1 = v.wr; m1 = v.mask;
        end
        #1;
        rdy = (v.port == 0) ? rdy0_a : rdy1_a;
        while (!rdy && waited < 8) begin
            step();
            waited++;
            rdy = (v.port == 0) ? rdy0_a : rdy1_a;
        end
        chk($sformatf("v%0d ready", idx), {31'b0, rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        chk($sformatf("v%0d memWrite in ACCESS", idx), {31'b0, mw_a}, {31'b0, v.wr & ~v.err});
        chk($sformatf("v%0d memAddress", idx), maddr_a, v.addr);
        chk($sformatf("v%0d byteMask", idx), {28'b0, bm_a}, {28'b0, v.mask});
        chk($sformatf("v%0d early respValid", idx), {31'b0, rv0_a | rv1_a}, 32'd0);
        step();
        rv       = (v.port == 0) ? rv0_a : rv1_a;
        rv_other = (v.port == 0) ? rv1_a : rv0_a;
        re       = (v.port == 0) ? re0_a : re1_a;
        rd       = (v.port == 0) ? rd0_a : rd1_a;
        chk($sformatf("v%0d respValid", idx), {30'b0, rv_other, rv}, 32'd1);
        chk($sformatf("v%0d respErr", idx), {31'b0, re}, {31'b0, v.err});
        chk($sformatf("v%0d respData", idx), rd, v.rdata);
        chk($sformatf("v%0d memWrite in RESP", idx), {31'b0, mw_a}, 32'd0);
        step();
        chk($sformatf("v%0d respValid after RESP", idx), {31'b0, rv0_a | rv1_a}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[16383] = 32'h1111_3FFF; mem_b[16383] = 32'h1111_3FFF;
        mem_a[16384] = 32'h2222_4000; mem_b[16384] = 32'h2222_4000;
        mem_a[32767] = 32'hCAFE_7FFF; mem_b[32767] = 32'hCAFE_7FFF;

        vecs[0]  = '{0, 1'b1, 32'd5,          32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'd5,          32'h0,        4'b1111, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1, 1'b0, 32'd32768,      32'h0,        4'b1111, 1'b1, 32'h0};
        vecs[3]  = '{1, 1'b1, 32'd3,          32'h5555AAAA, 4'b0110, 1'b1, 32'h0};
        vecs[4]  = '{1, 1'b0, 32'd32767,      32'h0,        4'b1111, 1'b0, 32'hCAFE_7FFF};
        vecs[5]  = '{0, 1'b1, 32'd9,          32'h12345678, 4'b0001, 1'b0, 32'h0};
        vecs[6]  = '{0, 1'b0, 32'd9,          32'h0,        4'b0000, 1'b0, 32'h0000_0078};
        vecs[7]  = '{1, 1'b1, 32'd9,          32'hAABBCCDD, 4'b0011, 1'b0, 32'h0};
        vecs[8]  = '{1, 1'b0, 32'd9,          32'h0,        4'b1111, 1'b0, 32'h0000_CCDD};
        vecs[9]  = '{0, 1'b0, 32'hFFFF_FFFF,  32'h0,        4'b1111, 1'b1, 32'h0};
        vecs[10] = '{0, 1'b1, 32'd4,          32'h99999999, 4'b0000, 1'b1, 32'h0};
        vecs[11] = '{0, 1'b0, 32'd3,          32'h0,        4'b1111, 1'b0, 32'h0};
        vecs[12] = '{0, 1'b1, 32'h8000_0005,  32'h77777777, 4'b1111, 1'b1, 32'h0};
        vecs[13] = '{0, 1'b0, 32'd5,          32'h0,        4'b1111, 1'b0, 32'hDEADBEEF};

        // Reset state, including a request presented while reset is held.
        step();
        v0 = 1'b1;
        #1;
        chk("reset reqReady0", {31'b0, rdy0_a}, 32'd0);
        chk("reset reqReady1", {31'b0, rdy1_a}, 32'd0);
        chk("reset respValid", {30'b0, rv1_a, rv0_a}, 32'd0);
        chk("reset respErr", {30'b0, re1_a, re0_a}, 32'd0);
        chk("reset respData0", rd0_a, 32'd0);
        chk("reset memWrite", {31'b0, mw_a}, 32'd0);
        chk("reset memAddress", maddr_a, 32'd0);
        chk("reset memWriteData", mwd_a, 32'd0);
        chk("reset byteMask", {28'b0, bm_a}, 32'hF);
        v0 = 1'b0;
        reset = 1'b0;
        step();

        for (int i = 0; i < 14; i++) do_txn(vecs[i], i);

        // Both requesters hold requests continuously.
        pulse_reset();
        v0 = 1'b1; a0 = 32'd16383; w0 = 1'b0; m0 = 4'b1111;
        v1 = 1'b1; a1 = 32'd16384; w1 = 1'b0; m1 = 4'b1111;
        #1;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) begin
                chk($sformatf("rr k%0d ready", k), {30'b0, rdy1_a, rdy0_a},
                    ((k / 2) % 2 == 0) ? 32'd1 : 32'd2);
                chk($sformatf("fp k%0d ready", k), {30'b0, rdy1_b, rdy0_b}, 32'd1);
                if (k >= 2) begin
                    if (((k / 2 - 1) % 2) == 0) begin
                        chk($sformatf("rr k%0d resp", k), {30'b0, rv1_a, rv0_a}, 32'd1);
                        chk($sformatf("rr k%0d data", k), rd0_a, 32'h1111_3FFF);
                    end else begin
                        chk($sformatf("rr k%0d resp", k), {30'b0, rv1_a, rv0_a}, 32'd2);
                        chk($sformatf("rr k%0d data", k), rd1_a, 32'h2222_4000);
                    end
                    chk($sformatf("fp k%0d resp", k), {30'b0, rv1_b, rv0_b}, 32'd1);
                    chk($sformatf("fp k%0d data", k), rd0_b, 32'h1111_3FFF);
                end
            end else begin
                chk($sformatf("rr k%0d idle ready", k), {30'b0, rdy1_a, rdy0_a}, 32'd0);
                chk($sformatf("rr k%0d no resp", k), {30'b0, rv1_a, rv0_a}, 32'd0);
                chk($sformatf("fp k%0d ready1", k), {31'b0, rdy1_b}, 32'd0);
            end
            step();
        end

        // Back-to-back reads: second request accepted during the first RESP.
        pulse_reset();
        v0 = 1'b1; a0 = 32'd16383; w0 = 1'b0; m0 = 4'b1111;
        #1;
        chk("b2b first ready", {31'b0, rdy0_a}, 32'd1);
        step();
        a0 = 32'd16384;
        #1;
        chk("b2b ready in ACCESS", {31'b0, rdy0_a}, 32'd0);
        step();
        chk("b2b first resp", {31'b0, rv0_a}, 32'd1);
        chk("b2b first data", rd0_a, 32'h1111_3FFF);
        chk("b2b ready in RESP", {31'b0, rdy0_a}, 32'd1);
        step();
        v0 = 1'b0;
        chk("b2b second addr", maddr_a, 32'd16384);
        chk("b2b no resp in ACCESS", {31'b0, rv0_a}, 32'd0);
        step();
        chk("b2b second resp", {31'b0, rv0_a}, 32'd1);
        chk("b2b second data", rd0_a, 32'h2222_4000);
        step();

        // Reset lands in the ACCESS cycle of a write.
        v0 = 1'b1; a0 = 32'd7; d0 = 32'h7777_0007; w0 = 1'b1; m0 = 4'b1111;
        #1;
        chk("rst-mid ready", {31'b0, rdy0_a}, 32'd1);
        step();
        v0 = 1'b0;
        #1;
        chk("rst-mid memWrite before", {31'b0, mw_a}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst-mid memWrite drop", {31'b0, mw_a}, 32'd0);
        chk("rst-mid memAddress", maddr_a, 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst-mid no resp %0d", k), {30'b0, rv1_a, rv0_a}, 32'd0);
        end
        v0 = 1'b1; a0 = 32'd7; w0 = 1'b0;
        v1 = 1'b1; a1 = 32'd7; w1 = 1'b0;
        #1;
        chk("rst-mid lastGrant=1", {30'b0, rdy1_a, rdy0_a}, 32'd1);
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        step();
        chk("rst-mid no write resp", {30'b0, rv1_a, rv0_a}, 32'd1);
        chk("rst-mid addr7 unwritten", rd0_a, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
